// File: rtl/alu_seq_unit_if.sv
// Request/response bundle for alu_seq_unit.
// valid/ready: a transfer happens on a rising clk edge where both are 1; the producer holds valid and payload until then.
interface alu_seq_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic        req_funct7b5;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rd;
   logic        busy;

   modport master (
      output req_valid, req_funct3, req_funct7b5, req_rs1, req_rs2, rsp_ready,
      input  req_ready, rsp_valid, rsp_rd, busy
   );

   modport slave (
      input  req_valid, req_funct3, req_funct7b5, req_rs1, req_rs2, rsp_ready,
      output req_ready, rsp_valid, rsp_rd, busy
   );
endinterface

// File: rtl/alu_seq_unit.sv
// RV32I ALU issue/response unit.
// Logic and arithmetic ops finish in one cycle; shifts step SHIFT_STEP bits per cycle.
module alu_seq_unit #(
   parameter int SHIFT_STEP = 1
) (
   input  logic           clk,
   input  logic           rst,
   alu_seq_unit_if.slave  bus,
   output logic [1:0]     o_dbg_state
);

   generate
      if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4 ||
            SHIFT_STEP == 8 || SHIFT_STEP == 16)) begin : g_bad_step
         $error("alu_seq_unit: SHIFT_STEP must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   localparam logic [4:0] STEP = 5'(SHIFT_STEP);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_rd;
   logic [31:0] r_shreg;
   logic [4:0]  r_cnt;
   logic        r_left;
   logic        r_arith;

   logic        w_accept;
   logic        w_is_shift;
   logic [4:0]  w_amt;
   logic [31:0] w_alu;
   logic [4:0]  w_s;
   logic [4:0]  w_cnt_nxt;
   logic [31:0] w_shifted;
   logic        w_unused_rs2;

   assign w_accept     = bus.req_valid && (r_state == IDLE);
   assign w_is_shift   = (bus.req_funct3 == 3'b001) || (bus.req_funct3 == 3'b101);
   assign w_amt        = bus.req_rs2[4:0];
   assign w_unused_rs2 = &{1'b0, bus.req_rs2[31:5]};

   always_comb begin
      w_alu = 32'h0;
      case (bus.req_funct3)
         3'b000:  w_alu = bus.req_funct7b5 ? (bus.req_rs1 - bus.req_rs2)
                                           : (bus.req_rs1 + bus.req_rs2);
         3'b010:  w_alu = {31'h0, $signed(bus.req_rs1) < $signed(bus.req_rs2)};
         3'b011:  w_alu = {31'h0, bus.req_rs1 < bus.req_rs2};
         3'b100:  w_alu = bus.req_rs1 ^ bus.req_rs2;
         3'b110:  w_alu = bus.req_rs1 | bus.req_rs2;
         3'b111:  w_alu = bus.req_rs1 & bus.req_rs2;
         default: w_alu = 32'h0;
      endcase
   end

   // The last step may be shorter than STEP; arithmetic right shift keeps re-copying rs1[31].
   always_comb begin
      w_s       = (r_cnt >= STEP) ? STEP : r_cnt;
      w_cnt_nxt = r_cnt - w_s;
      if (r_left)
         w_shifted = r_shreg << w_s;
      else if (r_arith)
         w_shifted = $signed(r_shreg) >>> w_s;
      else
         w_shifted = r_shreg >> w_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept)
               w_state_nxt = (w_is_shift && (w_amt != 5'd0)) ? SHIFT : DONE;
         end
         SHIFT: begin
            if (w_cnt_nxt == 5'd0) w_state_nxt = DONE;
         end
         DONE: begin
            if (bus.rsp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd    <= 32'h0;
         r_shreg <= 32'h0;
         r_cnt   <= 5'd0;
         r_left  <= 1'b0;
         r_arith <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (!w_is_shift) begin
                     r_rd <= w_alu;
                  end else if (w_amt == 5'd0) begin
                     r_rd <= bus.req_rs1;
                  end else begin
                     r_shreg <= bus.req_rs1;
                     r_cnt   <= w_amt;
                     r_left  <= (bus.req_funct3 == 3'b001);
                     r_arith <= (bus.req_funct3 == 3'b101) && bus.req_funct7b5;
                  end
               end
            end
            SHIFT: begin
               r_shreg <= w_shifted;
               r_cnt   <= w_cnt_nxt;
               if (w_cnt_nxt == 5'd0) r_rd <= w_shifted;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = (r_state == IDLE);
   assign bus.rsp_valid = (r_state == DONE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.rsp_rd    = r_rd;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed and random checks of alu_seq_unit with SHIFT_STEP of 1 and 4.
module tb_alu_seq_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_seq_unit_if bus1();
   alu_seq_unit_if bus4();
   logic [1:0] dbg1, dbg4;

   alu_seq_unit #(.SHIFT_STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .o_dbg_state(dbg1));
   alu_seq_unit #(.SHIFT_STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .o_dbg_state(dbg4));

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic b5,
                                             input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  return b5 ? a - b : a + b;
         3'b001:  return a << b[4:0];
         3'b010:  return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
         3'b011:  return (a < b) ? 32'h1 : 32'h0;
         3'b100:  return a ^ b;
         3'b101:  return b5 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  return a | b;
         default: return a & b;
      endcase
   endfunction

   // Issues one request with rsp_ready=1; lat counts edges after acceptance until rsp_valid.
   task automatic do_op(input bit use4, input logic [2:0] f3, input logic b5,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
      @(negedge clk);
      if (use4) begin
         bus4.req_funct3 = f3; bus4.req_funct7b5 = b5; bus4.req_rs1 = a; bus4.req_rs2 = b;
         bus4.req_valid = 1'b1; bus4.rsp_ready = 1'b1;
      end else begin
         bus1.req_funct3 = f3; bus1.req_funct7b5 = b5; bus1.req_rs1 = a; bus1.req_rs2 = b;
         bus1.req_valid = 1'b1; bus1.rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      bus1.req_valid = 1'b0;
      bus4.req_valid = 1'b0;
      lat = 0;
      while (!(use4 ? bus4.rsp_valid : bus1.rsp_valid) && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = use4 ? bus4.rsp_rd : bus1.rsp_rd;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      total += 8;
      if (bus1.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready1 got=%b exp=1", bus1.req_ready); end
      if (bus1.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid1 got=%b exp=0", bus1.rsp_valid); end
      if (bus1.rsp_rd !== 32'h0)   begin bad++; $display("FAIL reset_rsp_rd1 got=%h exp=0", bus1.rsp_rd); end
      if (bus1.busy !== 1'b0)      begin bad++; $display("FAIL reset_busy1 got=%b exp=0", bus1.busy); end
      if (bus4.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready4 got=%b exp=1", bus4.req_ready); end
      if (bus4.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid4 got=%b exp=0", bus4.rsp_valid); end
      if (bus4.rsp_rd !== 32'h0)   begin bad++; $display("FAIL reset_rsp_rd4 got=%h exp=0", bus4.rsp_rd); end
      if (bus4.busy !== 1'b0)      begin bad++; $display("FAIL reset_busy4 got=%b exp=0", bus4.busy); end
   endtask

   task automatic test_single_cycle;
      logic [2:0]  f3[7]  = '{3'b000, 3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};
      logic        b5[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [31:0] va[7]  = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h8000_0000,
                              32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
      logic [31:0] vb[7]  = '{32'h1, 32'h1, 32'h1, 32'h1,
                              32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0};
      logic [31:0] ex[7]  = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0,
                              32'hFF00_FF00, 32'hFFF0_FFF0, 32'h00F0_00F0};
      logic [31:0] res;
      int lat;
      for (int i = 0; i < 7; i++) begin
         do_op(1'b0, f3[i], b5[i], va[i], vb[i], res, lat);
         total += 2;
         if (res !== ex[i]) begin bad++; $display("FAIL single_result[%0d] got=%h exp=%h", i, res, ex[i]); end
         if (lat !== 0)     begin bad++; $display("FAIL single_latency[%0d] got=%0d exp=0", i, lat); end
      end
   endtask

   task automatic test_shift;
      bit          u4[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [2:0]  f3[6]  = '{3'b001, 3'b101, 3'b101, 3'b001, 3'b101, 3'b101};
      logic        b5[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] va[6]  = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF,
                              32'hF000_0000, 32'h8000_0000};
      logic [31:0] vb[6]  = '{32'h0000_0023, 32'd31, 32'd31, 32'h0000_0040, 32'd7, 32'd31};
      logic [31:0] ex[6]  = '{32'h8, 32'hFFFF_FFFF, 32'h1, 32'hDEAD_BEEF,
                              32'h01E0_0000, 32'hFFFF_FFFF};
      int          el[6]  = '{3, 31, 31, 0, 2, 8};
      logic [31:0] res;
      int lat;
      for (int i = 0; i < 6; i++) begin
         do_op(u4[i], f3[i], b5[i], va[i], vb[i], res, lat);
         total += 2;
         if (res !== ex[i]) begin bad++; $display("FAIL shift_result[%0d] got=%h exp=%h", i, res, ex[i]); end
         if (lat !== el[i]) begin bad++; $display("FAIL shift_latency[%0d] got=%0d exp=%0d", i, lat, el[i]); end
      end
   endtask

   task automatic test_back_pressure;
      bit stable = 1'b1;
      @(negedge clk);
      bus1.req_funct3 = 3'b000; bus1.req_funct7b5 = 1'b0;
      bus1.req_rs1 = 32'd5; bus1.req_rs2 = 32'd7;
      bus1.req_valid = 1'b1; bus1.rsp_ready = 1'b0;
      @(posedge clk); #1;
      // A second request stays pending while the first result is stalled.
      bus1.req_funct3 = 3'b100; bus1.req_rs1 = 32'hA5A5_A5A5; bus1.req_rs2 = 32'hFFFF_0000;
      total += 2;
      if (bus1.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", bus1.rsp_valid); end
      if (bus1.rsp_rd !== 32'd12)  begin bad++; $display("FAIL bp_result got=%h exp=0000000c", bus1.rsp_rd); end
      repeat (10) begin
         @(posedge clk); #1;
         if (bus1.rsp_valid !== 1'b1 || bus1.rsp_rd !== 32'd12 || bus1.req_ready !== 1'b0) stable = 1'b0;
      end
      total++;
      if (!stable) begin bad++; $display("FAIL bp_stable got=0 exp=1 (rd=%h ready=%b)", bus1.rsp_rd, bus1.req_ready); end
      @(negedge clk);
      bus1.rsp_ready = 1'b1;
      @(posedge clk); #1;
      total += 2;
      if (bus1.req_ready !== 1'b1) begin bad++; $display("FAIL bp_after_hs_ready got=%b exp=1", bus1.req_ready); end
      if (bus1.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_after_hs_valid got=%b exp=0", bus1.rsp_valid); end
      @(posedge clk); #1;
      bus1.req_valid = 1'b0;
      total += 2;
      if (bus1.rsp_valid !== 1'b1)      begin bad++; $display("FAIL bp_held_valid got=%b exp=1", bus1.rsp_valid); end
      if (bus1.rsp_rd !== 32'h5A5A_A5A5) begin bad++; $display("FAIL bp_held_result got=%h exp=5a5aa5a5", bus1.rsp_rd); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_shift;
      bit quiet = 1'b1;
      @(negedge clk);
      bus1.req_funct3 = 3'b001; bus1.req_funct7b5 = 1'b0;
      bus1.req_rs1 = 32'h1; bus1.req_rs2 = 32'd20;
      bus1.req_valid = 1'b1; bus1.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus1.req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total += 4;
      if (bus1.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", bus1.rsp_valid); end
      if (bus1.rsp_rd !== 32'h0)   begin bad++; $display("FAIL rst_mid_rd got=%h exp=0", bus1.rsp_rd); end
      if (bus1.req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", bus1.req_ready); end
      if (bus1.busy !== 1'b0)      begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", bus1.busy); end
      @(negedge clk);
      rst = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus1.rsp_valid !== 1'b0) quiet = 1'b0;
      end
      total++;
      if (!quiet) begin bad++; $display("FAIL rst_mid_no_response got=1 exp=0"); end
   endtask

   task automatic test_random(input int n);
      int issued = 0;
      int recv   = 0;
      int cyc    = 0;
      bit acc;
      logic [31:0] e;
      bus1.req_valid = 1'b0;
      while (recv < n && cyc < n * 80) begin
         @(negedge clk);
         cyc++;
         if (!bus1.req_valid && issued < n && $urandom_range(0, 3) != 0) begin
            bus1.req_funct3   = 3'($urandom_range(0, 7));
            bus1.req_funct7b5 = 1'($urandom_range(0, 1));
            bus1.req_rs1      = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom();
            bus1.req_rs2      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            bus1.req_valid    = 1'b1;
         end
         bus1.rsp_ready = ($urandom_range(0, 2) != 0);
         acc = bus1.req_valid && bus1.req_ready;
         if (acc) begin
            exp_q.push_back(alu_model(bus1.req_funct3, bus1.req_funct7b5, bus1.req_rs1, bus1.req_rs2));
            issued++;
         end
         if (bus1.rsp_valid && bus1.rsp_ready) begin
            total++;
            recv++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL rand_spurious got=%h exp=none", bus1.rsp_rd);
            end else begin
               e = exp_q.pop_front();
               if (bus1.rsp_rd !== e) begin bad++; $display("FAIL rand_result[%0d] got=%h exp=%h", recv, bus1.rsp_rd, e); end
            end
         end
         @(posedge clk); #1;
         if (acc) bus1.req_valid = 1'b0;
      end
      total++;
      if (recv != n || exp_q.size() != 0) begin
         bad++; $display("FAIL rand_count got=%0d exp=%0d pending=%0d", recv, n, exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      bus1.req_valid = 1'b0; bus1.req_funct3 = 3'b0; bus1.req_funct7b5 = 1'b0;
      bus1.req_rs1 = 32'h0; bus1.req_rs2 = 32'h0; bus1.rsp_ready = 1'b0;
      bus4.req_valid = 1'b0; bus4.req_funct3 = 3'b0; bus4.req_funct7b5 = 1'b0;
      bus4.req_rs1 = 32'h0; bus4.req_rs2 = 32'h0; bus4.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_single_cycle();
      test_shift();
      test_back_pressure();
      test_reset_mid_shift();
      test_random(2000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
